// File: rtl/bist_ctl4.sv
// BIST sequencer for a 4-bit SISR: clears the SISR, streams LEN PRPG bits into it,
// then captures the signature and compares it with GOLDEN.
module bist_ctl4 #(
  parameter int         LEN    = 16,
  parameter int         CW     = 8,
  parameter logic [3:0] SEED   = 4'b0001,
  parameter logic [3:0] GOLDEN = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] sig,
  output logic       tst_bit,
  output logic       sisr_rst_b,
  output logic       window,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] sig_cap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [3:0]    p_r;
  logic [CW-1:0] cnt_r;
  logic          done_r;
  logic          pass_r;
  logic [3:0]    sig_cap_r;

  // x^4+x^3+1 Fibonacci step; the output bit is the MSB
  function automatic logic [3:0] prpg_next(input logic [3:0] v);
    return {v[2:0], v[3] ^ v[2]};
  endfunction

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state decode; start is only honoured in IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = CLEAR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLEAR: state_nxt_s = RUN;
      RUN: begin
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = CHECK;
        end else begin
          state_nxt_s = RUN;
        end
      end
      CHECK:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // PRPG, bit counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      p_r       <= SEED;
      cnt_r     <= '0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      sig_cap_r <= 4'h0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            p_r       <= SEED;
            cnt_r     <= '0;
            pass_r    <= 1'b0;
            sig_cap_r <= 4'h0;
          end
        end
        RUN: begin
          p_r   <= prpg_next(p_r);
          cnt_r <= cnt_r + CNT_ONE;
        end
        CHECK: begin
          // sig has absorbed all LEN bits and is stable here
          sig_cap_r <= sig;
          pass_r    <= (sig == GOLDEN);
          done_r    <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign tst_bit    = (state_r == RUN) ? p_r[3] : 1'b0;
  assign window     = (state_r == RUN);
  assign busy       = (state_r != IDLE);
  // clear reaches the SISR combinationally so it is held during reset as well
  assign sisr_rst_b = ~(rst | (state_r == CLEAR));
  assign done       = done_r;
  assign pass       = pass_r;
  assign sig_cap    = sig_cap_r;

endmodule

// File: tb/tb_bist_ctl4.sv
// Table-driven bench for bist_ctl4 with three parameterisations, each driving a
// behavioural SISR model q <= {q[2:0], i ^ q[3] ^ q[2]}.
module tb_bist_ctl4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;

  logic       tst_a, rb_a, win_a, busy_a, done_a, pass_a;
  logic       tst_b, rb_b, win_b, busy_b, done_b, pass_b;
  logic       tst_c, rb_c, win_c, busy_c, done_c, pass_c;
  logic [3:0] cap_a, cap_b, cap_c;
  logic [3:0] q_a, q_b, q_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bist_ctl4 #(.LEN(4), .CW(8), .SEED(4'b0001), .GOLDEN(4'h1)) u_a (
    .clk(clk), .rst(rst), .start(start), .sig(q_a), .tst_bit(tst_a), .sisr_rst_b(rb_a),
    .window(win_a), .busy(busy_a), .done(done_a), .pass(pass_a), .sig_cap(cap_a));

  bist_ctl4 #(.LEN(4), .CW(8), .SEED(4'b0001), .GOLDEN(4'h2)) u_b (
    .clk(clk), .rst(rst), .start(start), .sig(q_b), .tst_bit(tst_b), .sisr_rst_b(rb_b),
    .window(win_b), .busy(busy_b), .done(done_b), .pass(pass_b), .sig_cap(cap_b));

  bist_ctl4 #(.LEN(5), .CW(8), .SEED(4'b0001), .GOLDEN(4'h2)) u_c (
    .clk(clk), .rst(rst), .start(start), .sig(q_c), .tst_bit(tst_c), .sisr_rst_b(rb_c),
    .window(win_c), .busy(busy_c), .done(done_c), .pass(pass_c), .sig_cap(cap_c));

  always @(posedge clk) begin
    if (!rb_a) q_a <= 4'h0; else q_a <= {q_a[2:0], tst_a ^ q_a[3] ^ q_a[2]};
    if (!rb_b) q_b <= 4'h0; else q_b <= {q_b[2:0], tst_b ^ q_b[3] ^ q_b[2]};
    if (!rb_c) q_c <= 4'h0; else q_c <= {q_c[2:0], tst_c ^ q_c[3] ^ q_c[2]};
  end

  typedef struct {
    logic       rst;
    logic       start;
    logic [9:0] exp;  // {tst_bit, window, busy, done, pass, sisr_rst_b, sig_cap}
  } vec_t;

  localparam int NV = 33;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic r, input logic s, input logic t, input logic w,
                              input logic b, input logic d, input logic p, input logic rb,
                              input logic [3:0] sc);
    vec_t v;
    v.rst   = r;
    v.start = s;
    v.exp   = {t, w, b, d, p, rb, sc};
    return v;
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endtask

  function automatic logic [9:0] pack_a();
    return {tst_a, win_a, busy_a, done_a, pass_a, rb_a, cap_a};
  endfunction

  initial begin
    int lat;
    int wcnt;
    logic [9:0] got;

    //               rst st  tst win busy done pass rb  sig_cap
    vecs[0]  = mk(1, 0,  0,  0,  0,   0,   0,   0, 4'h0);
    vecs[1]  = mk(1, 0,  0,  0,  0,   0,   0,   0, 4'h0);
    vecs[2]  = mk(0, 0,  0,  0,  0,   0,   0,   1, 4'h0);
    vecs[3]  = mk(0, 1,  0,  0,  1,   0,   0,   0, 4'h0);  // CLEAR
    vecs[4]  = mk(0, 0,  0,  1,  1,   0,   0,   1, 4'h0);  // RUN p=0001
    vecs[5]  = mk(0, 0,  0,  1,  1,   0,   0,   1, 4'h0);  // p=0010
    vecs[6]  = mk(0, 1,  0,  1,  1,   0,   0,   1, 4'h0);  // p=0100, start ignored
    vecs[7]  = mk(0, 0,  1,  1,  1,   0,   0,   1, 4'h0);  // p=1000
    vecs[8]  = mk(0, 0,  0,  0,  1,   0,   0,   1, 4'h0);  // CHECK
    vecs[9]  = mk(0, 0,  0,  0,  0,   1,   1,   1, 4'h1);  // done
    vecs[10] = mk(0, 1,  0,  0,  1,   0,   0,   0, 4'h0);  // start in done cycle
    vecs[11] = mk(0, 0,  0,  1,  1,   0,   0,   1, 4'h0);
    vecs[12] = mk(0, 0,  0,  1,  1,   0,   0,   1, 4'h0);
    vecs[13] = mk(0, 0,  0,  1,  1,   0,   0,   1, 4'h0);
    vecs[14] = mk(0, 0,  1,  1,  1,   0,   0,   1, 4'h0);
    vecs[15] = mk(0, 0,  0,  0,  1,   0,   0,   1, 4'h0);
    vecs[16] = mk(0, 0,  0,  0,  0,   1,   1,   1, 4'h1);
    vecs[17] = mk(0, 0,  0,  0,  0,   0,   1,   1, 4'h1);  // result held
    vecs[18] = mk(0, 1,  0,  0,  1,   0,   0,   0, 4'h0);
    vecs[19] = mk(0, 0,  0,  1,  1,   0,   0,   1, 4'h0);
    vecs[20] = mk(0, 0,  0,  1,  1,   0,   0,   1, 4'h0);  // RUN cycle 2
    vecs[21] = mk(1, 0,  0,  0,  0,   0,   0,   0, 4'h0);  // reset mid-run
    vecs[22] = mk(0, 0,  0,  0,  0,   0,   0,   1, 4'h0);
    vecs[23] = mk(0, 0,  0,  0,  0,   0,   0,   1, 4'h0);
    vecs[24] = mk(0, 0,  0,  0,  0,   0,   0,   1, 4'h0);  // still no done
    vecs[25] = mk(0, 1,  0,  0,  1,   0,   0,   0, 4'h0);
    vecs[26] = mk(0, 0,  0,  1,  1,   0,   0,   1, 4'h0);
    vecs[27] = mk(0, 0,  0,  1,  1,   0,   0,   1, 4'h0);
    vecs[28] = mk(0, 0,  0,  1,  1,   0,   0,   1, 4'h0);
    vecs[29] = mk(0, 0,  1,  1,  1,   0,   0,   1, 4'h0);
    vecs[30] = mk(0, 0,  0,  0,  1,   0,   0,   1, 4'h0);
    vecs[31] = mk(0, 0,  0,  0,  0,   1,   1,   1, 4'h1);
    vecs[32] = mk(0, 0,  0,  0,  0,   0,   1,   1, 4'h1);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst   = vecs[i].rst;
      start = vecs[i].start;
      if (i == 21) begin
        // clear must reach the SISR before the edge; state still RUN
        #1;
        check("rst_immediate", {8'd0, rb_a, win_a}, {8'd0, 1'b0, 1'b1});
      end
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), pack_a(), vecs[i].exp);
      // fail-golden instance: {done, pass, busy, sig_cap}
      if (i == 9 || i == 16 || i == 31)
        check($sformatf("lenfail%0d", i), {3'd0, done_b, pass_b, busy_b, cap_b},
              {3'd0, 1'b1, 1'b0, 1'b0, 4'h1});
      // LEN=5 instance finishes one edge later
      if (i == 9 || i == 31)
        check($sformatf("len5_busy%0d", i), {3'd0, done_c, pass_c, busy_c, cap_c},
              {3'd0, 1'b0, 1'b0, 1'b1, 4'h0});
      if (i == 10 || i == 32)
        check($sformatf("len5_done%0d", i), {3'd0, done_c, pass_c, busy_c, cap_c},
              {3'd0, 1'b1, 1'b1, 1'b0, 4'h2});
    end

    // latency and window width measured with a bounded wait
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat  = 0;
    wcnt = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (win_a) wcnt++;
      if (done_a) begin
        lat = n;
        break;
      end
    end
    check("latency", 10'(lat), 10'd6);
    check("window_len", 10'(wcnt), 10'd4);
    check("final_result", {5'd0, pass_a, cap_a}, {5'd0, 1'b1, 4'h1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
